// File: rtl/lfsr_word_gen_if.sv
// Control and data bundle for lfsr_word_gen: seed/load/enable in, packed random words out.
// The generator is the slave; the consumer (game logic or bench) drives the master side.
interface lfsr_word_gen_if #(
   parameter int WIDTH = 10,
   parameter int OUT_W = 4
);
   logic [WIDTH-1:0] seed;
   logic             load_n;
   logic             enable;
   logic             out_ready;
   logic             out_valid;
   logic [OUT_W-1:0] out_data;
   logic             serial_out;
   logic [WIDTH-1:0] state;
   logic             lockup_flag;

   modport master (
      output seed, load_n, enable, out_ready,
      input  out_valid, out_data, serial_out, state, lockup_flag
   );

   modport slave (
      input  seed, load_n, enable, out_ready,
      output out_valid, out_data, serial_out, state, lockup_flag
   );
endinterface

// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR packing OUT_W serial bits per word; first word OUT_W+1 edges after enable.
// Completed words are held (LFSR frozen) until out_ready; a seed load aborts any partial/held word.
module lfsr_word_gen #(
   parameter int               WIDTH        = 10,
   parameter logic [WIDTH-1:0] TAPS         = 10'b0000001001,
   parameter int               OUT_W        = 4,
   parameter logic [WIDTH-1:0] DEFAULT_SEED = 10'h001
) (
   input  logic          clock,
   input  logic          reset,
   lfsr_word_gen_if.slave bus
);
   localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(OUT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GEN  = 2'd1,
      HOLD = 2'd2
   } fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] lfsr_step;
   logic [OUT_W-1:0] coll_q, coll_d;
   logic [OUT_W-1:0] coll_shift;
   logic [OUT_W-1:0] word_q, word_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             lock_q, lock_d;
   logic             seed_zero;

   assign seed_zero = (bus.seed == '0);
   assign lfsr_step = {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};

   // Oldest bit ends up in bit 0 once the word is complete.
   always_comb begin
      coll_shift            = coll_q >> 1;
      coll_shift[OUT_W-1]   = lfsr_q[0];
   end

   always_comb begin
      fsm_d   = fsm_q;
      lfsr_d  = lfsr_q;
      coll_d  = coll_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      lock_d  = lock_q;

      if (!bus.load_n) begin
         lfsr_d  = seed_zero ? DEFAULT_SEED : bus.seed;
         lock_d  = seed_zero;
         coll_d  = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         fsm_d   = IDLE;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (bus.enable) begin
                  fsm_d = GEN;
                  cnt_d = '0;
               end
            end
            GEN: begin
               if (bus.enable) begin
                  lfsr_d = lfsr_step;
                  coll_d = coll_shift;
                  if (cnt_q == LAST) begin
                     word_d  = coll_shift;
                     valid_d = 1'b1;
                     cnt_d   = '0;
                     fsm_d   = HOLD;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            HOLD: begin
               // The accept edge never steps the LFSR.
               if (bus.out_ready) begin
                  valid_d = 1'b0;
                  cnt_d   = '0;
                  fsm_d   = bus.enable ? GEN : IDLE;
               end
            end
            default: fsm_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fsm_q   <= IDLE;
         lfsr_q  <= DEFAULT_SEED;
         coll_q  <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         lock_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         lfsr_q  <= lfsr_d;
         coll_q  <= coll_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         lock_q  <= lock_d;
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_data    = word_q;
   assign bus.serial_out  = lfsr_q[0];
   assign bus.state       = lfsr_q;
   assign bus.lockup_flag = lock_q;
endmodule

// File: doc/lfsr_word_gen.md
Name: lfsr_word_gen

Overview:
Parametrised Fibonacci LFSR random-number generator, the successor to the fixed 10-bit serial RNG. It has configurable width and tap mask. Serial output bits are packed into OUT_W-bit words and delivered over a valid/ready handshake, with seed loading, pause/enable and zero-seed lock-up protection. It feeds game logic that consumes random words at its own pace.

Parameters:
WIDTH, 10, LFSR register width (>= 2)
TAPS, 10'b0000001001, feedback mask; feedback = XOR of state bits whose mask bit is 1 (default gives x^10+x^7+1, period 1023)
OUT_W, 4, bits per output word (1..WIDTH)
DEFAULT_SEED, 10'h001, nonzero value used on reset and in place of an all-zero seed

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
seed  in  WIDTH  value loaded when load_n low
load_n  in  1  active-low synchronous seed load; highest priority after reset
enable  in  1  1 = generate; 0 = pause stepping
out_ready  in  1  consumer accepts out_data this cycle
out_valid  out  1  out_data holds a complete word
out_data  out  OUT_W  packed random word
serial_out  out  1  current state[0]
state  out  WIDTH  current LFSR contents (debug)
lockup_flag  out  1  sticky: last load supplied an all-zero seed

Behaviour:
- Reset (async, any time): state=DEFAULT_SEED, FSM=IDLE, bit count=0, collector=0, out_data=0, out_valid=0, lockup_flag=0.
- Step: next_state = {^(state & TAPS), state[WIDTH-1:1]}. Collector <= {state[0], collector[OUT_W-1:1]}, using the pre-step state[0]. serial_out = state[0], combinational.
- Load (load_n=0 on an edge, any FSM state): state <= (seed==0 ? DEFAULT_SEED : seed); lockup_flag <= (seed==0); collector and count cleared; out_valid <= 0; FSM -> IDLE. This aborts any partial or held word.
- FSM IDLE: no stepping. If enable=1 and load_n=1 -> GEN with count=0.
- FSM GEN: each edge with enable=1 performs one step and count++. On the OUT_W-th step: out_data <= completed collector (including that step's bit), out_valid <= 1, FSM -> HOLD. enable=0 freezes state, collector and count; FSM stays in GEN.
- FSM HOLD: LFSR frozen; out_data and out_valid stable regardless of enable.
  - On an edge with out_ready=1: out_valid <= 0; FSM -> GEN (count=0) if enable=1, else IDLE.
  - No step occurs on the accept edge.
- Latency: first out_valid rises OUT_W+1 edges after enable is seen in IDLE, with enable held high. Steady throughput with out_ready=1 is one word per OUT_W+1 cycles.
- out_ready while out_valid=0 is ignored.
- Simultaneous load_n=0 and an accept: load wins, and the word is dropped.
- Nonzero state never reaches zero through stepping. All-zero state is only reachable via seed, which is substituted.
- lockup_flag clears only on reset or on a load with a nonzero seed.

Test Plan:
- Reset, load_n=0 with seed=10'h001, then enable=1 and out_ready=1 -> first word out_data=4'b0001 with state=10'h040; second word 4'b0000 with state=10'h204.
- Seed 10'h001, count raw steps with OUT_W=1 and out_ready=1 -> state returns to 10'h001 after exactly 1023 steps and never equals 0.
- Hold out_ready=0 for 5 cycles with out_valid=1 -> out_data, state and out_valid constant; word accepted on the first out_ready=1 edge, and out_valid=0 on the next cycle.
- Load seed=0 -> state=DEFAULT_SEED (10'h001), lockup_flag=1; then load 10'h155 -> lockup_flag=0, state=10'h155.
- Assert load_n=0 after 2 GEN steps, and separately during HOLD -> out_valid=0, FSM returns to IDLE, and the next word is built from the new seed with no stale bits.
- Assert reset mid-GEN with enable=0 pauses interleaved -> all outputs at reset values immediately, without waiting for a clock edge; pause cycles never advance the state.
